// File: rtl/key_event_decoder.sv
// Classifies debounced key flags into short/double/long/repeat event pulses plus a held level.
// Latency: all outputs registered, one cycle after the sampling edge; no backpressure (pulses are fire-and-forget).
module key_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 5_000_000,
    parameter int unsigned DCLICK_CYCLES = 15_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic press_flag,
    input  logic release_flag,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [31:0] LONG_TC   = 32'(LONG_CYCLES - 1);
    localparam logic [31:0] REPEAT_TC = 32'(REPEAT_CYCLES - 1);
    localparam logic [31:0] DCLICK_TC = 32'(DCLICK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED   = 3'd1,
        LONG_HELD = 3'd2,
        WAIT_2ND  = 3'd3,
        PRESSED_2 = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic        short_nxt, double_nxt, long_nxt, repeat_nxt, held_nxt;
    logic        press, rel;

    // Simultaneous press and release is contradictory; treat it as no event.
    assign press = press_flag & ~release_flag;
    assign rel   = release_flag & ~press_flag;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + 32'd1;
        short_nxt  = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (press) state_nxt = PRESSED;
            end
            PRESSED: begin
                if (rel) begin
                    state_nxt = WAIT_2ND;
                end else if (cnt == LONG_TC) begin
                    long_nxt  = 1'b1;
                    state_nxt = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (rel) begin
                    state_nxt = IDLE;
                end else if (cnt == REPEAT_TC) begin
                    repeat_nxt = 1'b1;
                    cnt_nxt    = 32'd0;
                end
            end
            WAIT_2ND: begin
                if (press) begin
                    double_nxt = 1'b1;
                    state_nxt  = PRESSED_2;
                end else if (cnt == DCLICK_TC) begin
                    short_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PRESSED_2: begin
                if (rel) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) cnt_nxt = 32'd0;
        held_nxt = (state_nxt == PRESSED) || (state_nxt == LONG_HELD) || (state_nxt == PRESSED_2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 32'd0;
            short_pulse  <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            short_pulse  <= short_nxt;
            double_pulse <= double_nxt;
            long_pulse   <= long_nxt;
            repeat_pulse <= repeat_nxt;
            held         <= held_nxt;
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed gesture scenarios for key_event_decoder with short time windows.
module tb_key_event_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic press_flag = 1'b0;
    logic release_flag = 1'b0;
    logic short_pulse, double_pulse, long_pulse, repeat_pulse, held;

    int checks = 0;
    int errors = 0;

    key_event_decoder #(
        .LONG_CYCLES  (20),
        .REPEAT_CYCLES(5),
        .DCLICK_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .press_flag  (press_flag),
        .release_flag(release_flag),
        .short_pulse (short_pulse),
        .double_pulse(double_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse),
        .held        (held)
    );

    always #5 clk = ~clk;

    // Observed vector: {held, short, double, long, repeat}
    function automatic logic [4:0] obs();
        return {held, short_pulse, double_pulse, long_pulse, repeat_pulse};
    endfunction

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {held,short,dbl,long,rep}=%b expected %b", tag, got, exp);
        end
    endtask

    function automatic bit press_at(input int id, input int e);
        case (id)
            1: return e == 10;
            2: return e == 10 || e == 17;
            3: return e == 10;
            4: return e == 10;
            5: return e == 10 || e == 50;
            6: return e == 10;
            7: return e == 10 || e == 21;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit release_at(input int id, input int e);
        case (id)
            1: return e == 15;
            2: return e == 13 || e == 30;
            3: return e == 42;
            4: return e == 30;
            5: return e == 40;
            6: return e == 10;
            7: return e == 13 || e == 25;
            default: return 1'b0;
        endcase
    endfunction

    // Hand-derived expectations from the gesture timelines.
    function automatic logic [4:0] expected(input int id, input int e);
        logic h, s, d, l, r;
        h = 1'b0; s = 1'b0; d = 1'b0; l = 1'b0; r = 1'b0;
        case (id)
            1: begin h = (e >= 10 && e < 15); s = (e == 23); end
            2: begin h = (e >= 10 && e < 13) || (e >= 17 && e < 30); d = (e == 17); end
            3: begin h = (e >= 10 && e < 42); l = (e == 30); r = (e == 35 || e == 40); end
            4: begin h = (e >= 10 && e < 30); s = (e == 38); end
            5: begin h = (e >= 10 && e < 33) || (e >= 50); l = (e == 30); end
            7: begin h = (e >= 10 && e < 13) || (e >= 21 && e < 25); d = (e == 21); end
            default: ;
        endcase
        return {h, s, d, l, r};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        press_flag = 1'b0;
        release_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", obs(), 5'b0);
        rst_n = 1'b1;
    endtask

    task automatic run_scenario(input int id, input int n_edges);
        do_reset();
        for (int e = 1; e <= n_edges; e++) begin
            press_flag   = press_at(id, e);
            release_flag = release_at(id, e);
            if (id == 5 && e == 33) begin
                rst_n = 1'b0;
                #1;
                check("s5 async_rst", obs(), 5'b0);
            end
            if (id == 5 && e == 36) rst_n = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("s%0d e%0d", id, e), obs(), expected(id, e));
        end
        press_flag = 1'b0;
        release_flag = 1'b0;
    endtask

    initial begin
        run_scenario(1, 30);
        run_scenario(2, 40);
        run_scenario(3, 50);
        run_scenario(4, 45);
        run_scenario(5, 55);
        run_scenario(6, 20);
        run_scenario(7, 35);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
